// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux path among four requesters, with at most MAX_HOLD transfers per grant.
// Latency: grant is registered one cycle after a request; y/out_valid are combinational from the current grant.
// Backpressure: out_ready=0 freezes the grant and the transfer count, and y keeps following the granted data.
module mux_4x1_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clock,
    input  logic               reset_b,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] data_in,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   y,
    output logic [3:0]         grant,
    output logic [1:0]         sel,
    output logic               busy
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_ptr_q, last_ptr_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;

    logic [1:0] rr_base;
    logic [1:0] rr_cand;
    logic [1:0] rr_idx;
    logic       rr_found;
    logic       xfer;
    logic       release_grant;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            sel_q      <= 2'd0;
            last_ptr_q <= 2'd3;
            grant_q    <= 4'd0;
            hold_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_ptr_q <= last_ptr_d;
            grant_q    <= grant_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // On release the search starts just after the releasing index, so it ends up lowest priority.
    always_comb begin
        rr_base  = (state_q == GRANT) ? sel_q : last_ptr_q;
        rr_found = 1'b0;
        rr_idx   = rr_base;
        rr_cand  = rr_base;
        for (int k = 4; k >= 1; k--) begin
            rr_cand = rr_base + 2'(k);
            if (req[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    assign xfer          = out_valid & out_ready;
    assign release_grant = !req[sel_q] || (xfer && (hold_cnt_q == HOLD_LAST));

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_ptr_d = last_ptr_q;
        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d    = GRANT;
                    sel_d      = rr_idx;
                    grant_d    = 4'b0001 << rr_idx;
                    hold_cnt_d = 4'd0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    last_ptr_d = sel_q;
                    if (rr_found) begin
                        sel_d      = rr_idx;
                        grant_d    = 4'b0001 << rr_idx;
                        hold_cnt_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'd0;
                    end
                end else if (xfer) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == GRANT);
        out_valid = busy && req[sel_q];
        y         = out_valid ? data_in[int'(sel_q)*WIDTH +: WIDTH] : '0;
        grant     = grant_q;
        sel       = sel_q;
    end

endmodule

// File: doc/mux_4x1_rr_arbiter.md
Name: mux_4x1_rr_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one 4-to-1 mux output path among four requesters.
- Each requester presents a request bit and a WIDTH-bit data word.
- The block selects one requester, drives the mux select and a one-hot grant, and streams that requester's data to a single consumer under a valid/ready handshake.
- A grant is bounded by MAX_HOLD transfers, so no requester can starve the others.

Parameters:
- WIDTH, 8, data word width per requester and of output y
- MAX_HOLD, 4, maximum accepted transfers per grant before forced re-arbitration (legal range 1..15)

Ports:
- clock  input  1  system clock, rising edge
- reset_b  input  1  asynchronous active-low reset
- req  input  4  request bits; req[i] is requester i
- data_in  input  4*WIDTH  requester i's word at data_in[i*WIDTH +: WIDTH]
- out_ready  input  1  consumer accepts y this cycle
- out_valid  output  1  y holds a valid word from the granted requester
- y  output  WIDTH  muxed data; forced to 0 when out_valid=0
- grant  output  4  one-hot grant, registered; 0 when idle
- sel  output  2  registered mux select (index of current or last grant)
- busy  output  1  high while in GRANT state

Behaviour:
- Reset (asynchronous on reset_b=0):
  - state=IDLE, sel=0, grant=0, hold_cnt=0, last_ptr=3 (requester 0 has first priority).
  - Outputs: out_valid=0, y=0, busy=0.
- States are IDLE and GRANT. All state, sel, grant and hold_cnt are registered; out_valid and y are combinational from those registers plus req, data_in and out_ready.
- Round-robin pick: search indices last_ptr+1, +2, +3, +4 (mod 4); the first index with req set wins.
- IDLE:
  - If req!=0 at a clock edge: sel<=winner, grant<=onehot(winner), hold_cnt<=0, state<=GRANT.
  - Grant latency is 1 cycle from request to grant.
- GRANT:
  - out_valid = req[sel]; y = data_in[sel] when out_valid, else 0.
  - A transfer occurs on a cycle with out_valid & out_ready; hold_cnt increments on each transfer only.
  - out_ready=0 stalls: hold_cnt, sel and grant are unchanged and y tracks data_in[sel] live.
- Release conditions, evaluated at each edge in GRANT:
  - (a) req[sel]=0, or
  - (b) a transfer occurs with hold_cnt==MAX_HOLD-1.
- On release:
  - last_ptr<=sel.
  - Re-arbitrate in the same edge using req masked per the rule below.
  - If a winner exists: load the new sel/grant, hold_cnt<=0, stay in GRANT (no idle bubble).
  - Otherwise: state<=IDLE, grant<=0, sel holds its value.
- Masking on release:
  - Cause (a): req[sel] is already 0.
  - Cause (b): the releasing requester is still eligible but has lowest priority. If it is the only requester, it is re-granted immediately with hold_cnt=0.
- Simultaneous events: a request rising on another index during a grant has no effect until release. A transfer and req[sel] falling cannot coincide, because out_valid=0 when req[sel]=0.
- Reset mid-grant: the grant is abandoned immediately and out_valid drops asynchronously. After reset, priority restarts at requester 0.
- Width rules: hold_cnt is 4 bits; last_ptr and sel wrap modulo 4.

Test Plan:
- Reset, then req=4'b0001, data_in[0]=8'hA5, out_ready=1 → grant=0001 and sel=0 one cycle later; out_valid=1, y=8'hA5; after 4 transfers a re-grant to requester 0 with hold_cnt reset and no idle cycle.
- req=4'b1111 held, out_ready=1, MAX_HOLD=4 → grant sequence 0,1,2,3,0, each grant lasting exactly 4 transfer cycles with no bubbles between grants.
- Granted to requester 2, out_ready=0 for 5 cycles, then 1 → out_valid=1 and y=data_in[2] throughout; hold_cnt frozen while stalled; exactly 4 transfers are accepted before release.
- Granted to requester 1 after 2 transfers; req[1] drops with req=4'b1000 → out_valid=0 that cycle; next edge grant=1000, sel=3.
- All requests drop while in GRANT → state IDLE, grant=0, out_valid=0, y=0, sel holds its last value; the next request from requester 0 with last_ptr=3 is granted in 1 cycle.
- reset_b pulsed low mid-grant (requester 3, hold_cnt=2) → out_valid and grant go to 0 immediately without waiting for a clock; after release with req=4'b1001, requester 0 is granted first.
